// File: rtl/exu_hpm_pkg.sv
// Shared constants and helpers for the machine hardware performance-monitor block.
// Holds the CSR address map, the mhpmevent OF bit position and an address-window helper.
package exu_hpm_pkg;

    typedef logic [11:0] csr_addr_t;

    localparam csr_addr_t CSR_MCOUNTINHIBIT = 12'h320;
    localparam csr_addr_t CSR_MCYCLE        = 12'hB00;
    localparam csr_addr_t CSR_MCYCLEH       = 12'hB80;
    localparam csr_addr_t CSR_MINSTRET      = 12'hB02;
    localparam csr_addr_t CSR_MINSTRETH     = 12'hB82;
    localparam csr_addr_t CSR_MHPMCNT_BASE  = 12'hB03;
    localparam csr_addr_t CSR_MHPMCNTH_BASE = 12'hB83;
    localparam csr_addr_t CSR_MHPMEVT_BASE  = 12'h323;

    localparam int MHPMEVT_OF_BIT = 31;
    localparam int HPM_SLOTS      = 29;

    // True when idx falls in the 29-entry architectural window starting at base.
    function automatic logic in_win(input csr_addr_t idx, input csr_addr_t base);
        return (idx >= base) && (idx < (base + 12'd29));
    endfunction

endpackage

// File: rtl/exu_hpm_if.sv
// CSR access bus shared between the EXU CSR file and the performance-monitor block.
interface exu_hpm_if;
    logic        csr_wen;
    logic        csr_ren;
    logic [11:0] csr_idx;
    logic [31:0] csr_wdat;
    logic [31:0] csr_rdat;
    logic        csr_hit;

    modport master (output csr_wen, csr_ren, csr_idx, csr_wdat,
                    input  csr_rdat, csr_hit);
    modport slave  (input  csr_wen, csr_ren, csr_idx, csr_wdat,
                    output csr_rdat, csr_hit);
endinterface

// File: rtl/exu_hpm_hpm_cnt.sv
// One CNT_W-bit counter with split 32-bit write halves, increment enable and an
// optional sticky overflow flag set only by an increment wrap.
module hpm_cnt #(
    parameter int CNT_W  = 64,
    parameter bit HAS_OF = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             wr_lo,
    input  logic             wr_hi,
    input  logic [31:0]      wdat,
    input  logic             of_wr,
    input  logic             of_wdat,
    output logic [CNT_W-1:0] cnt,
    output logic             of
);

    logic [CNT_W-1:0] cnt_r;
    logic             wrap_s;

    // A software write to either half takes priority over the increment.
    assign wrap_s = inc && !wr_lo && !wr_hi && (&cnt_r);
    assign cnt    = cnt_r;

    // Counter state: partial writes leave the other half untouched, no carry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (wr_lo || wr_hi) begin
            if (wr_lo) cnt_r[31:0]       <= wdat;
            if (wr_hi) cnt_r[CNT_W-1:32] <= wdat[CNT_W-33:0];
        end else if (inc) begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
        end
    end

    if (HAS_OF) begin : g_of
        logic of_r;

        // Sticky overflow: a hardware wrap beats a same-edge software clear.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                of_r <= 1'b0;
            end else if (wrap_s) begin
                of_r <= 1'b1;
            end else if (of_wr) begin
                of_r <= of_wdat;
            end
        end

        assign of = of_r;
    end else begin : g_no_of
        logic unused_of_s;
        assign unused_of_s = of_wr ^ of_wdat ^ wrap_s;
        assign of          = 1'b0;
    end

endmodule

// File: rtl/exu_hpm.sv
// Machine counter group: mcycle, minstret, NUM_HPM programmable event counters,
// mcountinhibit and the combined overflow interrupt, all on the EXU CSR bus.
module exu_hpm
    import exu_hpm_pkg::*;
#(
    parameter int NUM_HPM = 4,
    parameter int CNT_W   = 64,
    parameter int NUM_EVT = 16
) (
    input  logic               clk,
    input  logic               rst,
    exu_hpm_if.slave           csr,
    input  logic               in_retr,
    input  logic [NUM_EVT-1:0] evt_i,
    output logic               ovf_irq
);

    localparam int SEL_W     = $clog2(NUM_EVT + 1);
    localparam int EVT_PAD_W = 1 << SEL_W;
    localparam int NH        = (NUM_HPM > 0) ? NUM_HPM : 1;
    localparam logic [63:0] HPM_INH64 = ((64'd1 << NUM_HPM) - 64'd1) << 3;
    localparam logic [31:0] INH_MASK  = 32'h0000_0005 | HPM_INH64[31:0];

    logic [31:0]          inh_r;
    logic [EVT_PAD_W-1:0] evt_pad_s;
    logic [CNT_W-1:0]     cy_cnt_s;
    logic [CNT_W-1:0]     ir_cnt_s;
    logic                 cy_of_s;
    logic                 ir_of_s;
    logic [NH-1:0][31:0]  hpm_rd_s;
    logic [NH-1:0]        of_s;
    logic [31:0]          rd_s;
    logic                 hit_s;

    // mcountinhibit: only bits backed by a real counter are writable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inh_r <= 32'd0;
        end else if (csr.csr_wen && (csr.csr_idx == CSR_MCOUNTINHIBIT)) begin
            inh_r <= csr.csr_wdat & INH_MASK;
        end
    end

    // Slot 0 is the "no event" select; selects beyond NUM_EVT land on zero padding.
    always_comb begin
        evt_pad_s              = '0;
        evt_pad_s[NUM_EVT:1]   = evt_i;
    end

    hpm_cnt #(.CNT_W(CNT_W), .HAS_OF(1'b0)) u_cy (
        .clk     (clk),
        .rst     (rst),
        .inc     (!inh_r[0]),
        .wr_lo   (csr.csr_wen && (csr.csr_idx == CSR_MCYCLE)),
        .wr_hi   (csr.csr_wen && (csr.csr_idx == CSR_MCYCLEH)),
        .wdat    (csr.csr_wdat),
        .of_wr   (1'b0),
        .of_wdat (1'b0),
        .cnt     (cy_cnt_s),
        .of      (cy_of_s)
    );

    hpm_cnt #(.CNT_W(CNT_W), .HAS_OF(1'b0)) u_ir (
        .clk     (clk),
        .rst     (rst),
        .inc     (in_retr && !inh_r[2]),
        .wr_lo   (csr.csr_wen && (csr.csr_idx == CSR_MINSTRET)),
        .wr_hi   (csr.csr_wen && (csr.csr_idx == CSR_MINSTRETH)),
        .wdat    (csr.csr_wdat),
        .of_wr   (1'b0),
        .of_wdat (1'b0),
        .cnt     (ir_cnt_s),
        .of      (ir_of_s)
    );

    for (genvar g = 0; g < NUM_HPM; g++) begin : g_hpm
        localparam csr_addr_t A_EVT  = CSR_MHPMEVT_BASE  + 12'(g);
        localparam csr_addr_t A_CNT  = CSR_MHPMCNT_BASE  + 12'(g);
        localparam csr_addr_t A_CNTH = CSR_MHPMCNTH_BASE + 12'(g);

        logic [SEL_W-1:0] sel_r;
        logic [CNT_W-1:0] cnt_s;
        logic             of_one_s;
        logic             wr_evt_s;
        logic [31:0]      rd_one_s;

        assign wr_evt_s = csr.csr_wen && (csr.csr_idx == A_EVT);

        // Event select field of mhpmevent.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sel_r <= '0;
            end else if (wr_evt_s) begin
                sel_r <= csr.csr_wdat[SEL_W-1:0];
            end
        end

        hpm_cnt #(.CNT_W(CNT_W), .HAS_OF(1'b1)) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .inc     (evt_pad_s[sel_r] && !inh_r[3+g]),
            .wr_lo   (csr.csr_wen && (csr.csr_idx == A_CNT)),
            .wr_hi   (csr.csr_wen && (csr.csr_idx == A_CNTH)),
            .wdat    (csr.csr_wdat),
            .of_wr   (wr_evt_s),
            .of_wdat (csr.csr_wdat[MHPMEVT_OF_BIT]),
            .cnt     (cnt_s),
            .of      (of_one_s)
        );

        // This counter's contribution to the read OR-tree.
        always_comb begin
            rd_one_s = 32'd0;
            if (csr.csr_idx == A_EVT) begin
                rd_one_s[SEL_W-1:0]       = sel_r;
                rd_one_s[MHPMEVT_OF_BIT]  = of_one_s;
            end else if (csr.csr_idx == A_CNT) begin
                rd_one_s = cnt_s[31:0];
            end else if (csr.csr_idx == A_CNTH) begin
                rd_one_s = 32'(cnt_s[CNT_W-1:32]);
            end else begin
                rd_one_s = 32'd0;
            end
        end

        assign hpm_rd_s[g] = rd_one_s;
        assign of_s[g]     = of_one_s;
    end

    if (NUM_HPM == 0) begin : g_no_hpm
        assign hpm_rd_s[0] = 32'd0;
        assign of_s[0]     = 1'b0;
    end

    // Address decode covers all 29 architectural slots, implemented or not.
    always_comb begin
        hit_s = (csr.csr_idx == CSR_MCOUNTINHIBIT) ||
                (csr.csr_idx == CSR_MCYCLE)   || (csr.csr_idx == CSR_MCYCLEH) ||
                (csr.csr_idx == CSR_MINSTRET) || (csr.csr_idx == CSR_MINSTRETH) ||
                in_win(csr.csr_idx, CSR_MHPMEVT_BASE) ||
                in_win(csr.csr_idx, CSR_MHPMCNT_BASE) ||
                in_win(csr.csr_idx, CSR_MHPMCNTH_BASE);
    end

    // Read OR-tree over the fixed registers and every programmable counter.
    always_comb begin
        case (csr.csr_idx)
            CSR_MCOUNTINHIBIT: rd_s = inh_r;
            CSR_MCYCLE:        rd_s = cy_cnt_s[31:0];
            CSR_MCYCLEH:       rd_s = 32'(cy_cnt_s[CNT_W-1:32]);
            CSR_MINSTRET:      rd_s = ir_cnt_s[31:0];
            CSR_MINSTRETH:     rd_s = 32'(ir_cnt_s[CNT_W-1:32]);
            default:           rd_s = 32'd0;
        endcase
        for (int k = 0; k < NH; k++) begin
            rd_s = rd_s | hpm_rd_s[k];
        end
    end

    assign csr.csr_hit  = hit_s;
    assign csr.csr_rdat = (csr.csr_ren && hit_s && !rst) ? rd_s : 32'd0;
    assign ovf_irq      = (|of_s) | cy_of_s | ir_of_s;

endmodule

// File: doc/exu_hpm.md
Name: exu_hpm

Overview:
- Parametrised successor to the core's fixed mcycle/minstret CSR logic.
- Implements the machine counter group:
  - mcycle and minstret
  - NUM_HPM programmable mhpmcounter/mhpmevent pairs
  - mcountinhibit
  - per-counter sticky overflow flags, combined into one overflow interrupt request
- Sits in the EXU beside the main CSR file, on the same csr_idx/csr_wen/csr_ren/csr_wdat bus.
- Its csr_rdat is ORed into the main CSR read mux, qualified by csr_hit.

Parameters:
- NUM_HPM, 4, number of implemented programmable counters, legal 0..29. Counters are mhpmcounter3 .. mhpmcounter(3+NUM_HPM-1).
- CNT_W, 64, width of every counter, legal 33..64.
- NUM_EVT, 16, number of event inputs, legal 1..255.

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- csr_wen  in  1  CSR write strobe
- csr_ren  in  1  CSR read strobe
- csr_idx  in  12  CSR address
- csr_wdat  in  32  CSR write data, already merged for csrrs/csrrc
- csr_rdat  out  32  read data; 0 when not hit or csr_ren=0
- csr_hit  out  1  csr_idx belongs to this block
- in_retr  in  1  one instruction retired this cycle
- evt_i  in  NUM_EVT  event pulses, sampled every cycle
- ovf_irq  out  1  OR of all implemented OF flags

Behaviour:
- Address map:
  - mcountinhibit 0x320
  - mhpmevent3+i at 0x323+i
  - mcycle 0xB00 / mcycleh 0xB80
  - minstret 0xB02 / minstreth 0xB82
  - mhpmcounter3+i at 0xB03+i / 0xB83+i
  - csr_hit=1 for every address above for i=0..28, including unimplemented counters.
  - Unimplemented counters read 0 and ignore writes. All other addresses: csr_hit=0, writes ignored.
- Reset: all counters, event selects, OF flags and mcountinhibit go to 0. ovf_irq=0 and csr_rdat=0 while in reset.
- Read:
  - Combinational, same cycle, shows register state before this cycle's edge.
  - High half returns counter[CNT_W-1:32], zero-extended to 32 bits.
- Increment conditions, per clock edge, unless inhibited:
  - mcycle increments by 1 every cycle.
  - minstret increments when in_retr=1.
  - hpm i increments when sel_i!=0 and evt_i[sel_i-1]=1.
  - sel_i values above NUM_EVT never count.
- mcountinhibit:
  - bit0 inhibits CY, bit2 inhibits IR, bit3+i inhibits HPM i.
  - bit1 and bits of unimplemented counters are hardwired 0.
  - An inhibit write takes effect from the next edge; the write cycle itself still counts per the old value.
- Counter write:
  - A low-half write replaces bits[31:0].
  - A high-half write replaces bits[CNT_W-1:32]; wdat bits above CNT_W-32 are dropped.
  - Either write suppresses that counter's increment on the same edge (write wins).
  - The other half keeps its value; there is no carry from a written low half.
- Wrap: all-ones plus 1 gives 0, on every counter.
- mhpmevent layout:
  - [SEL_W-1:0] = sel, where SEL_W = clog2(NUM_EVT+1).
  - [31] = OF.
  - All other bits read 0.
- OF flag:
  - OF_i sets on the edge where hpm i wraps to 0 by increment. A wrap caused by a write does not set it.
  - Software writes OF via mhpmevent, to set or clear it.
  - If a hardware set and a software clear hit the same edge, the set wins.
  - mcycle and minstret have no OF.
- ovf_irq = |OF, driven from registers. It rises the cycle after the wrapping edge and stays high until software clears every OF.
- Single-cycle CSR access, no stall, no back-pressure. csr_wen and csr_ren may both be high: the read returns the old value and the write lands at the edge.
- NUM_HPM=0 yields only CY/IR and the inhibit register. ovf_irq is then tied 0.

Decomposition:
- Shared package holds:
  - CSR address constants: CSR_MCOUNTINHIBIT, CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH, CSR_MHPMCNT_BASE, CSR_MHPMCNTH_BASE, CSR_MHPMEVT_BASE.
  - MHPMEVT_OF_BIT=31.
- One sub-module, hpm_cnt:
  - Contains the CNT_W counter, lo/hi write ports, increment enable, wrap detect and OF register.
  - Instantiated for CY and IR (OF unused) and in a generate loop for NUM_HPM counters.
- Top level holds address decode, event select mux, mcountinhibit and the read OR-tree.

Test Plan:
- Reset, then read 0xB00 after 10 idle cycles -> csr_rdat=10. The 0xB80 read -> 0. ovf_irq=0 throughout.
- Write mhpmevent3 sel=2, then pulse evt_i[1] 5 times -> mhpmcounter3 reads 5. Pulses on evt_i[0] leave it unchanged. sel=0 freezes it.
- Write mhpmcounter3=0xFFFFFFFF and mhpmcounter3h=0xFFFFFFFF (CNT_W=64), then one event -> counter reads 0. OF (mhpmevent3 bit31) reads 1. ovf_irq rises one cycle after the wrap edge.
- Write 0 to mhpmevent3 bit31 on the same edge as a second wrap -> OF stays 1. Clear with no wrap -> ovf_irq falls the next cycle.
- Write mcountinhibit=0x5, then 8 cycles with in_retr=1 -> mcycle and minstret unchanged. mcountinhibit reads back 0x5, bit1 reads 0.
- Low-half write with an event on the same edge -> counter equals written value exactly. CNT_W=40: write 0xFFFFFFFF to the high half -> reads back 0xFF. Unimplemented mhpmcounter20 read -> csr_hit=1, data 0. Address 0x7C0 -> csr_hit=0.
